// File: rtl/sys_timer.sv
// Memory-mapped timer/PWM slave on the picorv32 native bus: 16-bit prescaler,
// 32-bit up-counter with period match, one-shot/auto-reload, level IRQ and one PWM output.
module sys_timer #(
    parameter logic        PWM_POL    = 1'b1,
    parameter logic [31:0] RST_PERIOD = 32'hFFFF_FFFF
) (
    input  logic        clk_24,
    input  logic        reset,
    input  logic        cs,
    input  logic [3:0]  we,
    input  logic [2:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        rdy,
    output logic        irq,
    output logic        pwm_out
);

    localparam int unsigned DW = 32;
    localparam int unsigned PW = 16;
    localparam int unsigned CW = 4;
    localparam int unsigned AW = 3;

    localparam logic [AW-1:0] A_CTRL   = AW'(0);
    localparam logic [AW-1:0] A_PRESC  = AW'(1);
    localparam logic [AW-1:0] A_PERIOD = AW'(2);
    localparam logic [AW-1:0] A_DUTY   = AW'(3);
    localparam logic [AW-1:0] A_COUNT  = AW'(4);
    localparam logic [AW-1:0] A_STATUS = AW'(5);

    logic [CW-1:0] ctrl;
    logic [PW-1:0] presc;
    logic [PW-1:0] pcnt;
    logic [DW-1:0] period;
    logic [DW-1:0] duty;
    logic [DW-1:0] count;
    logic          flag;

    logic          en, auto_rl, irq_en, pwm_en;
    logic          acc_c, wr_c, tick_c, match_c;
    logic          wr_ctrl_c, wr_presc_c, wr_period_c, wr_duty_c, wr_count_c, clr_flag_c;
    logic [DW-1:0] rd_data_c;

    assign en      = ctrl[0];
    assign auto_rl = ctrl[1];
    assign irq_en  = ctrl[2];
    assign pwm_en  = ctrl[3];

    // Exactly one access edge per cs assertion: the cycle before rdy pulses.
    assign acc_c = cs & ~rdy;
    assign wr_c  = acc_c & (|we);

    assign wr_ctrl_c   = wr_c & (addr == A_CTRL) & we[0];
    assign wr_presc_c  = wr_c & (addr == A_PRESC);
    assign wr_period_c = wr_c & (addr == A_PERIOD);
    assign wr_duty_c   = wr_c & (addr == A_DUTY);
    assign wr_count_c  = wr_c & (addr == A_COUNT);
    assign clr_flag_c  = wr_c & (addr == A_STATUS) & we[0] & din[0];

    // A CPU write to COUNT suppresses match evaluation on a coincident tick.
    assign tick_c  = en & (pcnt == presc);
    assign match_c = tick_c & ~wr_count_c & (count == period);

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] nw,
                                            input logic [3:0]    be);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    // Read mux, sampled into dout on the access edge.
    always_comb begin
        rd_data_c = '0;
        case (addr)
            A_CTRL:   rd_data_c = {(DW-CW)'(0), ctrl};
            A_PRESC:  rd_data_c = {(DW-PW)'(0), presc};
            A_PERIOD: rd_data_c = period;
            A_DUTY:   rd_data_c = duty;
            A_COUNT:  rd_data_c = count;
            A_STATUS: rd_data_c = {(DW-1)'(0), flag};
            default:  rd_data_c = '0;
        endcase
    end

    always_ff @(posedge clk_24) begin
        if (reset) begin
            ctrl    <= '0;
            presc   <= '0;
            pcnt    <= '0;
            period  <= RST_PERIOD;
            duty    <= '0;
            count   <= '0;
            flag    <= 1'b0;
            rdy     <= 1'b0;
            dout    <= '0;
            irq     <= 1'b0;
            pwm_out <= ~PWM_POL;
        end else begin
            rdy <= cs & ~rdy;
            if (acc_c) dout <= rd_data_c;

            // CPU write to EN takes priority over the one-shot auto-clear.
            if (wr_ctrl_c)                ctrl    <= din[CW-1:0];
            else if (match_c && !auto_rl) ctrl[0] <= 1'b0;

            if (wr_presc_c && we[0]) presc[7:0]  <= din[7:0];
            if (wr_presc_c && we[1]) presc[15:8] <= din[15:8];
            if (wr_period_c) period <= merge(period, din, we);
            if (wr_duty_c)   duty   <= merge(duty, din, we);

            if (wr_count_c)   count <= merge(count, din, we);
            else if (match_c) count <= auto_rl ? '0 : count;
            else if (tick_c)  count <= count + DW'(1);

            // Set has priority over write-1-to-clear.
            if (match_c)         flag <= 1'b1;
            else if (clr_flag_c) flag <= 1'b0;

            if (!en || wr_presc_c || tick_c) pcnt <= '0;
            else                             pcnt <= pcnt + PW'(1);

            irq <= flag & irq_en;

            // Output freezes while the timer is disabled.
            if (en) pwm_out <= (pwm_en && (count < duty)) ? PWM_POL : ~PWM_POL;
        end
    end

endmodule
